// File: rtl/spu_imm_pkg.sv
// Shared types and helpers for the immediate-narrowing pipeline.
// Field selector encoding, field widths and width/mask lookups.
package spu_imm_pkg;

  typedef enum logic [1:0] {
    I7  = 2'b00,
    I10 = 2'b01,
    I16 = 2'b10,
    I18 = 2'b11
  } imm_sel_t;

  localparam int unsigned W_I7    = 7;
  localparam int unsigned W_I10   = 10;
  localparam int unsigned W_I16   = 16;
  localparam int unsigned W_I18   = 18;
  localparam int unsigned VAL_W   = 32;
  localparam int unsigned FIELD_W = 18;
  localparam int unsigned WID_W   = 5;

  // Field width N for a selector.
  function automatic logic [WID_W-1:0] imm_width(imm_sel_t sel);
    logic [WID_W-1:0] w;
    case (sel)
      I7:      w = WID_W'(W_I7);
      I10:     w = WID_W'(W_I10);
      I16:     w = WID_W'(W_I16);
      default: w = WID_W'(W_I18);
    endcase
    return w;
  endfunction

  // Mask of the low N bits of the widest field.
  function automatic logic [FIELD_W-1:0] imm_mask(imm_sel_t sel);
    logic [FIELD_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < FIELD_W; i++) begin
      m[i] = (i < 32'(imm_width(sel)));
    end
    return m;
  endfunction

endpackage

// File: rtl/imm_range_chk.sv
// Combinational signed range check of a 32-bit value against the
// N-bit field chosen by the selector. Also returns the field limits
// as N-bit patterns (upper bits of the 18-bit bus are don't-care,
// the caller masks them).
module imm_range_chk
  import spu_imm_pkg::*;
(
  input  logic [VAL_W-1:0]   i_value,
  input  imm_sel_t           i_sel,
  output logic               o_fits,
  output logic [FIELD_W-1:0] o_min,
  output logic [FIELD_W-1:0] o_max
);

  logic [WID_W-1:0] w_n;
  logic [VAL_W-1:0] w_max;
  logic [VAL_W-1:0] w_min;

  // Limits are +2^(N-1)-1 and its bitwise complement -2^(N-1).
  always_comb begin
    w_n    = imm_width(i_sel);
    w_max  = (VAL_W'(1) << (w_n - WID_W'(1))) - VAL_W'(1);
    w_min  = ~w_max;
    o_fits = ($signed(i_value) >= $signed(w_min)) &&
             ($signed(i_value) <= $signed(w_max));
    o_min  = w_min[FIELD_W-1:0];
    o_max  = w_max[FIELD_W-1:0];
  end

endmodule

// File: rtl/imm_narrow.sv
// Two-stage valid/ready pipeline narrowing a signed 32-bit immediate
// to a 7/10/16/18-bit field, flagging overflow and counting delivered
// overflows in a saturating counter.
// S1 holds the low input bits, sign, selector, fit flag and limits;
// S2 holds the finished field, width and overflow flag.
// Build option: define IMM_SATURATE_EN to clamp overflowed values to
// the field min/max; otherwise overflowed values are truncated.
module imm_narrow
  import spu_imm_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [VAL_W-1:0]   in_value,
  input  logic [1:0]         in_select,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [FIELD_W-1:0] out_field,
  output logic [WID_W-1:0]   out_width,
  output logic               out_ovf,
  output logic [CNT_W-1:0]   ovf_count,
  input  logic               clr_count
);

`ifdef IMM_SATURATE_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  imm_sel_t           w_sel;
  logic               w_fits;
  logic [FIELD_W-1:0] w_min;
  logic [FIELD_W-1:0] w_max;
  logic               w_s1_load;
  logic               w_s2_load;
  logic               w_out_hs;
  logic [FIELD_W-1:0] w_s2_field;
  logic [WID_W-1:0]   w_s2_width;

  logic               r_s1_valid;
  logic [FIELD_W-1:0] r_s1_raw;
  logic               r_s1_neg;
  imm_sel_t           r_s1_sel;
  logic               r_s1_fits;
  logic [FIELD_W-1:0] r_s1_min;
  logic [FIELD_W-1:0] r_s1_max;

  logic               r_s2_valid;
  logic [FIELD_W-1:0] r_s2_field;
  logic [WID_W-1:0]   r_s2_width;
  logic               r_s2_ovf;
  logic [CNT_W-1:0]   r_ovf_count;

  assign w_sel = imm_sel_t'(in_select);

  imm_range_chk u_range_chk (
    .i_value (in_value),
    .i_sel   (w_sel),
    .o_fits  (w_fits),
    .o_min   (w_min),
    .o_max   (w_max)
  );

  // Stage enables: S2 advances when empty or drained; S1 when empty or
  // S2 takes its contents. in_ready is forced low while in reset.
  always_comb begin
    w_s2_load = !r_s2_valid || out_ready;
    w_s1_load = !r_s1_valid || w_s2_load;
    in_ready  = w_s1_load && !rst;
    w_out_hs  = r_s2_valid && out_ready;
  end

  // S1: capture input bits, sign, selector and range-check result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_raw   <= '0;
      r_s1_neg   <= 1'b0;
      r_s1_sel   <= I7;
      r_s1_fits  <= 1'b0;
      r_s1_min   <= '0;
      r_s1_max   <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_raw  <= in_value[FIELD_W-1:0];
        r_s1_neg  <= in_value[VAL_W-1];
        r_s1_sel  <= w_sel;
        r_s1_fits <= w_fits;
        r_s1_min  <= w_min;
        r_s1_max  <= w_max;
      end
    end
  end

  // Select truncated or clamped bits, then keep only the low N bits.
  always_comb begin
    w_s2_width = imm_width(r_s1_sel);
    if (!r_s1_fits && SAT_EN) begin
      w_s2_field = r_s1_neg ? r_s1_min : r_s1_max;
    end else begin
      w_s2_field = r_s1_raw;
    end
    w_s2_field = w_s2_field & imm_mask(r_s1_sel);
  end

  // S2: output register; payload is zeroed whenever it holds no result
  // so the outputs read zero while out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_field <= '0;
      r_s2_width <= '0;
      r_s2_ovf   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      r_s2_field <= r_s1_valid ? w_s2_field : '0;
      r_s2_width <= r_s1_valid ? w_s2_width : '0;
      r_s2_ovf   <= r_s1_valid && !r_s1_fits;
    end
  end

  // Saturating count of delivered overflows; clear has priority.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf_count <= '0;
    end else if (clr_count) begin
      r_ovf_count <= '0;
    end else if (w_out_hs && r_s2_ovf && (r_ovf_count != '1)) begin
      r_ovf_count <= r_ovf_count + CNT_W'(1);
    end
  end

  assign out_valid = r_s2_valid;
  assign out_field = r_s2_field;
  assign out_width = r_s2_width;
  assign out_ovf   = r_s2_ovf;
  assign ovf_count = r_ovf_count;

endmodule

// File: tb/tb_imm_narrow.sv
// Self-checking bench for imm_narrow: directed cases plus randomized
// traffic scored against an arithmetic reference model and queue.
module tb_imm_narrow;

  localparam int unsigned CW   = 4;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_value = '0;
  logic [1:0]  in_select = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [17:0] out_field;
  logic [4:0]  out_width;
  logic        out_ovf;
  logic [CW-1:0] ovf_count;
  logic        clr_count = 1'b0;

  always #5 clk = ~clk;

  imm_narrow #(.CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_select (in_select),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_field (out_field),
    .out_width (out_width),
    .out_ovf   (out_ovf),
    .ovf_count (ovf_count),
    .clr_count (clr_count)
  );

  typedef struct {
    logic [17:0] f;
    logic [4:0]  w;
    logic        o;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned mcnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: range and field from integer arithmetic on the signed value.
  function automatic exp_t model(input logic [31:0] v, input logic [1:0] s);
    exp_t   e;
    int     n;
    longint sv, p, hi, lo, t;
    case (s)
      2'd0:    n = 7;
      2'd1:    n = 10;
      2'd2:    n = 16;
      default: n = 18;
    endcase
    sv  = longint'($signed(v));
    p   = longint'(1) << n;
    hi  = p / 2 - 1;
    lo  = -(p / 2);
    e.o = (sv < lo) || (sv > hi);
    t   = sv;
`ifdef IMM_SATURATE_EN
    if (sv < lo) t = lo;
    else if (sv > hi) t = hi;
`endif
    t   = ((t % p) + p) % p;
    e.f = t[17:0];
    e.w = n[4:0];
    return e;
  endfunction

  task automatic drive(input logic v, input int val, input logic [1:0] s);
    in_valid  = v;
    in_value  = val;
    in_select = s;
  endtask

  // One clock: score handshakes at the negedge, check the counter after the edge.
  task automatic cycle();
    exp_t e;
    @(negedge clk);
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_out", {31'd0, out_valid}, 32'd0);
      end else begin
        e = q.pop_front();
        chk("field", {14'd0, out_field}, {14'd0, e.f});
        chk("width", {27'd0, out_width}, {27'd0, e.w});
        chk("ovf",   {31'd0, out_ovf},   {31'd0, e.o});
        if (e.o && mcnt != CMAX) mcnt++;
      end
    end else if (!out_valid) begin
      chk("idle_zero", {8'd0, out_ovf, out_width, out_field}, 32'd0);
    end
    if (in_valid && in_ready) q.push_back(model(in_value, in_select));
    if (clr_count) mcnt = 0;
    @(posedge clk);
    #1;
    chk("ovf_count", {28'd0, ovf_count}, mcnt);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_count",     {28'd0, ovf_count}, 32'd0);
    chk("rst_outs",      {8'd0, out_ovf, out_width, out_field}, 32'd0);
    q.delete();
    mcnt = 0;
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [17:0] exp33, exp34;
`ifdef IMM_SATURATE_EN
    exp33 = 18'h001FF;
    exp34 = 18'h20000;
`else
    exp33 = 18'h00200;
    exp34 = 18'h1FFFF;
`endif
    do_reset();

    // I7 boundaries
    out_ready = 1'b1;
    drive(1'b1, -64, 2'd0); cycle();
    drive(1'b1, 63, 2'd0);  cycle();
    chk("i7_min_field", {14'd0, out_field}, 32'h40);
    chk("i7_min_width", {27'd0, out_width}, 32'd7);
    chk("i7_min_ovf",   {31'd0, out_ovf},   32'd0);
    in_valid = 1'b0; cycle();
    chk("i7_max_field", {14'd0, out_field}, 32'h3F);
    chk("i7_max_ovf",   {31'd0, out_ovf},   32'd0);
    cycle();

    // I10 overflow
    drive(1'b1, 512, 2'd1); cycle();
    in_valid = 1'b0; cycle();
    chk("i10_ovf_field", {14'd0, out_field}, {14'd0, exp33});
    chk("i10_ovf_flag",  {31'd0, out_ovf},   32'd1);
    cycle();
    chk("i10_ovf_count", {28'd0, ovf_count}, 32'd1);

    // I18 boundary and one below
    drive(1'b1, -131072, 2'd3); cycle();
    drive(1'b1, -131073, 2'd3); cycle();
    chk("i18_min_field", {14'd0, out_field}, 32'h20000);
    chk("i18_min_ovf",   {31'd0, out_ovf},   32'd0);
    in_valid = 1'b0; cycle();
    chk("i18_ovf_field", {14'd0, out_field}, {14'd0, exp34});
    chk("i18_ovf_flag",  {31'd0, out_ovf},   32'd1);
    cycle();
    chk("i18_ovf_count", {28'd0, ovf_count}, 32'd2);

    // Backpressure: two held, third waits, all emerge in order
    out_ready = 1'b0;
    drive(1'b1, 100, 2'd2); cycle();
    drive(1'b1, -5, 2'd2);  cycle();
    chk("bp_ready_low", {31'd0, in_ready}, 32'd0);
    drive(1'b1, 40000, 2'd2);
    repeat (3) cycle();
    chk("bp_still_full", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("bp_drained", q.size(), 32'd0);

    // Clear wins over an overflowed output handshake
    out_ready = 1'b0;
    drive(1'b1, 200, 2'd0); cycle();
    in_valid = 1'b0; cycle();
    clr_count = 1'b1; out_ready = 1'b1;
    cycle();
    chk("clr_wins", {28'd0, ovf_count}, 32'd0);
    clr_count = 1'b0;

    // Reset with two values in flight and a nonzero counter
    drive(1'b1, -1000, 2'd0); cycle();
    in_valid = 1'b0; repeat (2) cycle();
    out_ready = 1'b0;
    drive(1'b1, 70000, 2'd2); cycle();
    drive(1'b1, 3, 2'd1);     cycle();
    in_valid = 1'b0;
    chk("pre_rst_count", {28'd0, ovf_count}, 32'd1);
    do_reset();

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      int          mode;
      int          n;
      int          b;
      logic [1:0]  s;
      int          v;
      s    = 2'($urandom_range(0, 3));
      mode = $urandom_range(0, 3);
      n    = (s == 2'd0) ? 7 : (s == 2'd1) ? 10 : (s == 2'd2) ? 16 : 18;
      b    = 1 << (n - 1);
      case (mode)
        0:       v = int'($urandom);
        1:       v = $urandom_range(0, 255) - 128;
        2:       v = b - 2 + $urandom_range(0, 3);
        default: v = -b - 2 + $urandom_range(0, 3);
      endcase
      drive($urandom_range(0, 9) < 7, v, s);
      out_ready = $urandom_range(0, 9) < 7;
      clr_count = $urandom_range(0, 59) == 0;
      cycle();
    end
    in_valid = 1'b0; clr_count = 1'b0; out_ready = 1'b1;
    repeat (5) cycle();
    chk("final_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_narrow.md
IMM_NARROW -- requirements
Module: imm_narrow

Interface
REQ-001 Parameter: CNT_W, 16, width of the overflow event counter.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_valid  input  1  upstream offers a value.
REQ-005 in_ready  output  1  block accepts the value this cycle.
REQ-006 in_value  input  32  signed immediate to narrow.
REQ-007 in_select  input  2  target field: 00=I7, 01=I10, 10=I16, 11=I18.
REQ-008 out_valid  output  1  result available.
REQ-009 out_ready  input  1  downstream accepts the result.
REQ-010 out_field  output  18  narrowed field, right-justified, unused upper bits zero.
REQ-011 out_width  output  5  field width N: 7, 10, 16 or 18.
REQ-012 out_ovf  output  1  in_value outside the signed N-bit range.
REQ-013 ovf_count  output  CNT_W  count of overflowed results delivered.
REQ-014 clr_count  input  1  synchronous clear of ovf_count.

Function
REQ-015 The block SHALL be a two-stage pipeline: S1 registers the input and range-check result; S2 registers the output fields.
REQ-016 Input handshake SHALL occur when in_valid && in_ready; output handshake SHALL occur when out_valid && out_ready.
REQ-017 S2 SHALL load when !S2.valid || out_ready; S1 SHALL load when !S1.valid || S2 loads; in_ready SHALL equal the S1 load condition.
REQ-018 Latency SHALL be 2 cycles from input handshake to out_valid with no backpressure; sustained throughput SHALL be 1 per cycle.
REQ-019 A held stage SHALL keep its contents unchanged; ordering SHALL be preserved; no value SHALL be dropped or duplicated.
REQ-020 A value SHALL fit iff -2^(N-1) <= in_value <= 2^(N-1)-1, compared as signed 32-bit; out_ovf SHALL be the negation of fit.
REQ-021 If the value fits, out_field SHALL be in_value[N-1:0]; sign-extending out_field[N-1:0] back to 32 bits SHALL reproduce in_value.
REQ-022 On overflow, out_field SHALL follow REQ-037/REQ-038.
REQ-023 ovf_count SHALL increment by 1 on each output handshake with out_ovf=1 and SHALL saturate at all-ones.
REQ-024 If clr_count is asserted, ovf_count SHALL become 0 next cycle; clear SHALL win over a simultaneous increment.
REQ-025 out_field, out_width and out_ovf SHALL be zero whenever out_valid=0.

Reset
REQ-026 While rst=1, S1.valid, S2.valid and ovf_count SHALL be 0, and all outputs SHALL be 0; in_ready SHALL be 0.
REQ-027 Reset asserted mid-operation SHALL discard in-flight values immediately (asynchronously); no partial result SHALL be emitted.
REQ-028 in_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-029 The macro IMM_SATURATE_EN SHALL select the overflow policy.
REQ-037 With IMM_SATURATE_EN defined, an overflowed value SHALL be replaced by the field minimum (-2^(N-1)) or maximum (2^(N-1)-1), according to its sign.
REQ-038 Without IMM_SATURATE_EN, out_field SHALL be in_value[N-1:0] (truncation); out_ovf SHALL still be flagged.

Structure
REQ-030 Package spu_imm_pkg SHALL hold imm_sel_t (I7, I10, I16, I18 with the encodings above), the width localparams, and the function imm_width(sel).
REQ-031 Combinational sub-module imm_range_chk (value, sel -> fits, min, max) SHALL be instantiated in S1.

Verification
REQ-032 I7, in_value -64 then 63, out_ready=1 -> after 2 cycles, out_field 0x40 then 0x3F, out_ovf=0, out_width=7.
REQ-033 I10, in_value 512 -> out_ovf=1, out_field 0x200 (truncate) or 0x1FF (saturate); ovf_count=1.
REQ-034 I18, in_value -131072 -> out_field 0x20000, ovf=0; then -131073 -> ovf=1, out_field 0x1FFFF (truncate) or 0x20000 (saturate).
REQ-035 Three inputs sent back-to-back with out_ready=0 for 5 cycles -> in_ready drops once 2 are held; when out_ready rises, all 3 emerge in order unchanged.
REQ-036 rst pulsed with 2 values in flight -> out_valid=0 at once, ovf_count=0; clr_count in the same cycle as an overflowed output handshake -> ovf_count=0.
